// File: rtl/chan_pipe_pkg.sv
// Shared defaults and types for the chan_pipe_proc datapath.
// Parameter defaults live here so the top and the bench agree on them.
package chan_pipe_pkg;

  localparam int unsigned DefWidth      = 8;
  localparam int unsigned DefChannels   = 2;
  localparam int unsigned DefDepth      = 2;
  localparam int unsigned DefOffset     = 5;
  localparam int unsigned DefThresh     = 10;
  localparam int unsigned DefHoldOffset = 3;
  localparam int unsigned DefCntW       = 32;

  typedef logic [DefWidth-1:0] chan_t;
  typedef logic [DefCntW-1:0]  count_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/chan_pipe_if.sv
// Handshake/data bundle between the capture stage and chan_pipe_proc.
// master drives beats and the strobe; slave is the datapath.
interface chan_pipe_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 32
) ();

  logic                      in_valid;
  logic [CHANNELS*WIDTH-1:0] data_in;
  logic                      edge_sig;
  logic [CHANNELS*WIDTH-1:0] data_out_comb;
  logic [CHANNELS*WIDTH-1:0] data_out_ff;
  logic                      out_valid;
  logic [CHANNELS*WIDTH-1:0] hold_data;
  logic                      out_toggle_always;
  logic                      out_toggle_edge;
  logic [CNT_W-1:0]          beat_count;

  modport master (
    output in_valid, data_in, edge_sig,
    input  data_out_comb, data_out_ff, out_valid, hold_data,
    input  out_toggle_always, out_toggle_edge, beat_count
  );

  modport slave (
    input  in_valid, data_in, edge_sig,
    output data_out_comb, data_out_ff, out_valid, hold_data,
    output out_toggle_always, out_toggle_edge, beat_count
  );

endinterface

// File: rtl/edge_sync_toggle.sv
// Two-flop synchroniser for an asynchronous strobe; every settled edge
// (rising or falling) inverts toggle_out.
module edge_sync_toggle (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic toggle_out
);

  logic sync1_q, sync2_q, prev_q, toggle_q;
  logic toggle_d;

  always_comb begin
    toggle_d = toggle_q ^ (sync2_q ^ prev_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      sync1_q  <= async_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      toggle_q <= toggle_d;
    end
  end

  assign toggle_out = toggle_q;

endmodule

// File: rtl/chan_pipe_proc.sv
// Multi-channel offset pipeline with threshold hold, beat counter and toggles.
// Define CHAN_PIPE_SAT_EN to make beat_count saturate instead of wrapping.
module chan_pipe_proc
  import chan_pipe_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned CHANNELS    = DefChannels,
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned OFFSET      = DefOffset,
  parameter int unsigned THRESH      = DefThresh,
  parameter int unsigned HOLD_OFFSET = DefHoldOffset,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic        clk,
  input  logic        rst,
  chan_pipe_if.slave  bus
);

  typedef logic [WIDTH-1:0] data_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Threshold compare runs at >= 32 bits so THRESH is never truncated.
  localparam int unsigned CmpW = max_u(WIDTH, 32);
  localparam logic [CmpW-1:0] ThreshC = CmpW'(THRESH);

  data_t            din      [CHANNELS];
  data_t            stage_q  [DEPTH][CHANNELS];
  data_t            stage0_d [CHANNELS];
  logic [DEPTH-1:0] valid_q;
  data_t            hold_q   [CHANNELS];
  data_t            hold_d   [CHANNELS];
  cnt_t             count_q, count_d;
  logic             toggle_q;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      din[c]      = bus.data_in[c*WIDTH +: WIDTH];
      stage0_d[c] = stage_q[0][c];
      hold_d[c]   = hold_q[c];
      if (bus.in_valid) begin
        stage0_d[c] = din[c] + data_t'(OFFSET);
        if (CmpW'(din[c]) > ThreshC) hold_d[c] = din[c] + data_t'(HOLD_OFFSET);
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (bus.in_valid) begin
`ifdef CHAN_PIPE_SAT_EN
      if (count_q != '1) count_d = count_q + cnt_t'(1);
`else
      count_d = count_q + cnt_t'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      count_q  <= '0;
      toggle_q <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        hold_q[c] <= '0;
        for (int d = 0; d < DEPTH; d++) stage_q[d][c] <= '0;
      end
    end else begin
      valid_q[0] <= bus.in_valid;
      count_q    <= count_d;
      toggle_q   <= toggle_q ^ bus.in_valid;
      for (int c = 0; c < CHANNELS; c++) begin
        hold_q[c]     <= hold_d[c];
        stage_q[0][c] <= stage0_d[c];
      end
      // Later stages shift every cycle; valid travels with the data.
      for (int d = 1; d < DEPTH; d++) begin
        valid_q[d] <= valid_q[d-1];
        for (int c = 0; c < CHANNELS; c++) stage_q[d][c] <= stage_q[d-1][c];
      end
    end
  end

  always_comb begin
    bus.data_out_comb = '0;
    bus.data_out_ff   = '0;
    bus.hold_data     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.data_out_comb[c*WIDTH +: WIDTH] = stage_q[0][c] + data_t'(1);
      bus.data_out_ff[c*WIDTH +: WIDTH]   = stage_q[DEPTH-1][c];
      bus.hold_data[c*WIDTH +: WIDTH]     = hold_q[c];
    end
    bus.out_valid         = valid_q[DEPTH-1];
    bus.beat_count        = count_q;
    bus.out_toggle_always = toggle_q;
  end

  edge_sync_toggle u_edge_sync_toggle (
    .clk        (clk),
    .rst        (rst),
    .async_in   (bus.edge_sig),
    .toggle_out (bus.out_toggle_edge)
  );

endmodule

// File: tb/tb_chan_pipe_proc.sv
// Scoreboard bench for chan_pipe_proc: a default instance plus a CNT_W=4
// instance sharing the same stimulus for the counter overflow check.
module tb_chan_pipe_proc;

  localparam int unsigned D = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] data_in = '0;
  logic        edge_sig = 1'b0;

  always #5 clk = ~clk;

  chan_pipe_if #(.WIDTH(8), .CHANNELS(2), .CNT_W(32)) bus ();
  chan_pipe_if #(.WIDTH(8), .CHANNELS(2), .CNT_W(4))  bus4 ();

  assign bus.in_valid  = in_valid;
  assign bus.data_in   = data_in;
  assign bus.edge_sig  = edge_sig;
  assign bus4.in_valid = in_valid;
  assign bus4.data_in  = data_in;
  assign bus4.edge_sig = edge_sig;

  chan_pipe_proc #(
    .WIDTH(8), .CHANNELS(2), .DEPTH(D), .OFFSET(5), .THRESH(10), .HOLD_OFFSET(3), .CNT_W(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  chan_pipe_proc #(
    .WIDTH(8), .CHANNELS(2), .DEPTH(D), .OFFSET(5), .THRESH(10), .HOLD_OFFSET(3), .CNT_W(4)
  ) dut_c4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: out_valid must be high exactly when a beat is due.
  always @(negedge clk) begin
    logic exp_v;
    exp_v = (sb_q.size() > 0) && (sb_q[0].due == cyc);
    check_eq("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_v});
    if (exp_v) begin
      check_eq("data_out_ff", {48'd0, bus.data_out_ff}, {48'd0, sb_q[0].data});
      void'(sb_q.pop_front());
    end
  end

  logic [7:0]  m_hold [2];
  int unsigned m_cnt;
  logic        m_tog;

  task automatic clear_model();
    sb_q.delete();
    m_hold[0] = '0;
    m_hold[1] = '0;
    m_cnt     = 0;
    m_tog     = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic beat(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    data_in  = {b, a};
    sb_q.push_back('{data: {b + 8'd5, a + 8'd5}, due: cyc + D});
    if (a > 8'd10) m_hold[0] = a + 8'd3;
    if (b > 8'd10) m_hold[1] = b + 8'd3;
    m_cnt++;
    m_tog = ~m_tog;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("hold_data", {48'd0, bus.hold_data}, {48'd0, m_hold[1], m_hold[0]});
    check_eq("beat_count", {32'd0, bus.beat_count}, {32'd0, m_cnt});
    check_eq("toggle_always", {63'd0, bus.out_toggle_always}, {63'd0, m_tog});
    check_eq("data_out_comb", {48'd0, bus.data_out_comb}, {48'd0, b + 8'd6, a + 8'd6});
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_vld"}, {63'd0, bus.out_valid}, 64'd0);
    check_eq({tag, "_ff"}, {48'd0, bus.data_out_ff}, 64'd0);
    check_eq({tag, "_comb"}, {48'd0, bus.data_out_comb}, 64'h0101);
    check_eq({tag, "_hold"}, {48'd0, bus.hold_data}, 64'd0);
    check_eq({tag, "_cnt"}, {32'd0, bus.beat_count}, 64'd0);
    check_eq({tag, "_tog"}, {63'd0, bus.out_toggle_always}, 64'd0);
  endtask

  // Asserted between edges so the monitor's negedge samples are undisturbed.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    clear_model();
    #1;
    check_reset_state("rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic edge_step(input string tag, input logic exp);
    @(posedge clk);
    #1;
    check_eq(tag, {63'd0, bus.out_toggle_edge}, {63'd0, exp});
  endtask

  initial begin
    clear_model();
    #3;
    check_reset_state("init");
    check_eq("init_edge_tog", {63'd0, bus.out_toggle_edge}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Basic pipeline latency and comb output.
    beat(8'h10, 8'h20);
    idle(3);

    // Hold threshold and wrap.
    beat(8'h0A, 8'h0B);
    beat(8'h05, 8'hFE);
    idle(3);

    // Back-to-back beats from a clean pipeline.
    do_reset();
    for (int i = 0; i < 7; i++) beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    check_eq("cnt7", {32'd0, bus.beat_count}, 64'd7);
    check_eq("tog7", {63'd0, bus.out_toggle_always}, 64'd1);
    idle(3);

    // Narrow counter overflow behaviour.
    do_reset();
    for (int i = 0; i < 20; i++) beat(8'(i * 13), 8'(255 - i));
`ifdef CHAN_PIPE_SAT_EN
    check_eq("cnt4_ovf", {60'd0, bus4.beat_count}, 64'd15);
`else
    check_eq("cnt4_ovf", {60'd0, bus4.beat_count}, 64'd4);
`endif
    idle(3);

    // Synchronised strobe, both edges.
    edge_sig = 1'b1;
    edge_step("edge_r1", 1'b0);
    edge_step("edge_r2", 1'b0);
    edge_step("edge_r3", 1'b1);
    repeat (2) @(negedge clk);
    edge_sig = 1'b0;
    edge_step("edge_f1", 1'b1);
    edge_step("edge_f2", 1'b1);
    edge_step("edge_f3", 1'b0);
    @(negedge clk);

    // Reset with beats in flight; nothing stale may emerge afterwards.
    beat(8'h21, 8'h31);
    beat(8'h22, 8'h32);
    do_reset();
    idle(4);
    beat(8'h30, 8'h40);
    idle(4);

    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chan_pipe_proc.md
# chan_pipe_proc

Multi-channel, parametrised registered datapath that replaces the single-channel register/latch/toggle block. Per channel it adds a fixed offset and pipelines the result, keeps a flop-based threshold hold register, counts accepted beats, and toggles an output on both edges of a synchronised asynchronous strobe. It sits between the input capture stage and downstream consumers. All storage is flop-based; no latches.

## Interface
- `WIDTH`, 8, data width per channel
- `CHANNELS`, 2, number of parallel channels (≥1)
- `DEPTH`, 2, pipeline stages from input to `data_out_ff` (≥1)
- `OFFSET`, 5, constant added at stage 0
- `THRESH`, 10, unsigned hold threshold
- `HOLD_OFFSET`, 3, constant added on hold capture
- `CNT_W`, 32, beat counter width
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  beat accepted when high
- `data_in`  in  CHANNELS*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- `edge_sig`  in  1  asynchronous strobe; both edges counted
- `data_out_comb`  out  CHANNELS*WIDTH  stage-0 value + 1, combinational
- `data_out_ff`  out  CHANNELS*WIDTH  final pipeline stage
- `out_valid`  out  1  qualifies `data_out_ff`
- `hold_data`  out  CHANNELS*WIDTH  per-channel threshold hold
- `out_toggle_always`  out  1  toggles on every accepted beat
- `out_toggle_edge`  out  1  toggles on every synchronised edge of `edge_sig`
- `beat_count`  out  CNT_W  accepted-beat count

## Operation
- Reset (`rst`=0, asynchronous): all pipeline stages, valid bits, `hold_data`, counter, both toggles, sync flops → 0. Hence `data_out_comb` = 1 per channel during reset.
- Stage 0: on accepted beat, per channel `s0 <= data_in + OFFSET`, truncated mod 2^WIDTH; valid bit set. No beat: valid bit cleared, data held.
- Stages 1..DEPTH-1 shift unconditionally (data and valid). `data_out_ff` / `out_valid` = last stage.
- `data_out_comb` = `s0 + 1` mod 2^WIDTH per channel, independent of valid.
- Hold: per channel, on accepted beat with `data_in[c] > THRESH` (strict, unsigned), `hold_data[c] <= data_in[c] + HOLD_OFFSET` mod 2^WIDTH; otherwise retains. Channels independent.
- Counter: +1 per accepted beat; overflow behaviour per Configuration. `out_toggle_always` inverts on the same edge.
- Edge path: `edge_sig` → 2-flop synchroniser → compare with third flop; mismatch inverts `out_toggle_edge`.

## Timing
- Beat at edge N → `data_out_ff` valid after edge N+DEPTH-1 (DEPTH=1: visible immediately after edge N). Full throughput, no back-pressure.
- `data_out_comb` reflects edge-N beat after edge N (zero added latency).
- `beat_count`, `out_toggle_always`, `hold_data` update at the accepting edge.
- `edge_sig` change sampled at edge K → `out_toggle_edge` inverts after edge K+2. Pulses narrower than one clock period, or two edges between samples, may be missed/cancel; documented, not an error.
- Reset asserted mid-stream: in-flight beats discarded, `out_valid` drops immediately; first post-reset beat sees empty pipeline.

## Configuration
- `CHAN_PIPE_SAT_EN` defined: `beat_count` saturates at 2^CNT_W−1; toggle continues.
- Undefined: `beat_count` wraps to 0 after 2^CNT_W−1.

## Structure
- Package `chan_pipe_pkg`: `chan_t` (logic [WIDTH-1:0]) via parametrised typedef helpers, default constants for OFFSET/THRESH/HOLD_OFFSET, count type.
- Sub-module `edge_sync_toggle`: synchroniser + both-edge detector + toggle flop, ports `clk`, `rst`, `async_in`, `toggle_out`.

## Test plan
- Reset release, defaults, one beat `data_in`={0x10,0x20} → after 2 cycles `data_out_ff`={0x15,0x25}, `out_valid`=1 for one cycle; `data_out_comb`={0x16,0x26} after edge 1.
- Beats {0x0A,0x0B} then {0x05,0xFE} → `hold_data` ch0 stays 0, ch1 = 0x0E then 0x01 (wrap); `data_out_ff` ch1 = 0x03 (wrap).
- 7 back-to-back beats → `beat_count`=7, `out_toggle_always`=1, `out_valid` high 7 consecutive cycles.
- CNT_W=4 with `CHAN_PIPE_SAT_EN`: 20 beats → `beat_count`=15; without macro → 4.
- `edge_sig` 0→1, held 5 cycles, 1→0 → `out_toggle_edge` 1 at 3rd edge after rise, 0 at 3rd edge after fall.
- Reset asserted while 2 beats in flight → outputs 0 immediately, `out_valid`=0; no stale beat emerges after release.
